// File: rtl/keypad_encoder_if.sv
// Keypad-side bundle of the keypad encoder.
// Latency: none; this is wiring only.
// Backpressure: none; loadn is a one-shot strobe that the timer must take.
// Ports:
//   keypad[9:0] raw key lines, inhibit (timer counting),
//   data[3:0] BCD digit, loadn active-low strobe, busy entry in progress.
// The master side drives the keys and the inhibit. The slave side is the encoder.
`timescale 1ns/1ps
interface keypad_encoder_if;
  logic [9:0] keypad;
  logic       inhibit;
  logic [3:0] data;
  logic       loadn;
  logic       busy;

  modport master (
    output keypad,
    output inhibit,
    input  data,
    input  loadn,
    input  busy
  );

  modport slave (
    input  keypad,
    input  inhibit,
    output data,
    output loadn,
    output busy
  );
endinterface

// File: rtl/keypad_encoder.sv
// Ten-key pad to BCD loader: sync, debounce, chord reject, one loadn strobe per press.
// Latency: a key stable before edge k gives loadn low after edge k+1+DEBOUNCE_CYCLES, for one clock.
// Backpressure: inhibit blocks new entries and aborts a debounce. A held key never re-strobes.
// Ports:
//   clock, clearn   rising-edge clock and async active-low reset
//   kp (slave)      keypad/inhibit in; data/loadn/busy out
`timescale 1ns/1ps
module keypad_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4   // 1..255
) (
  input  logic            clock,
  input  logic            clearn,
  keypad_encoder_if.slave kp
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    LOAD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam bit         SINGLE_CYC = (DEBOUNCE_CYCLES == 1);

  state_t     state;
  logic [9:0] sync_q;
  logic [9:0] keys_s;
  logic [9:0] cand;
  logic [7:0] cnt;
  logic       onehot;

  // Exactly one key down. The all-zero pattern and chords are both rejected.
  assign onehot = (keys_s != 10'd0) && ((keys_s & (keys_s - 10'd1)) == 10'd0);

  assign kp.busy = (state != IDLE);

  // Index of the set bit. The caller guarantees the argument is one-hot.
  function automatic logic [3:0] key_index(input logic [9:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      sync_q   <= '0;
      keys_s   <= '0;
      cand     <= '0;
      cnt      <= '0;
      state    <= IDLE;
      kp.data  <= 4'd0;
      kp.loadn <= 1'b1;
    end else begin
      sync_q <= kp.keypad;
      keys_s <= sync_q;

      case (state)
        IDLE: begin
          if (onehot && !kp.inhibit) begin
            cand <= keys_s;
            cnt  <= 8'd1;
            if (SINGLE_CYC) begin
              // A single matching sample already satisfies the debounce.
              state    <= LOAD;
              kp.loadn <= 1'b0;
              kp.data  <= key_index(keys_s);
            end else begin
              state <= DEBOUNCE;
            end
          end
        end

        DEBOUNCE: begin
          // The inhibit check comes first, so it wins on the edge that would otherwise load.
          if (kp.inhibit || (keys_s != cand)) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end else if (cnt == CNT_LAST) begin
            state    <= LOAD;
            kp.loadn <= 1'b0;
            kp.data  <= key_index(cand);
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        LOAD: begin
          kp.loadn <= 1'b1;
          cnt      <= 8'd0;
          state    <= RELEASE;
        end

        RELEASE: begin
          // Re-arm only after a full run of all-keys-up samples. Any key activity,
          // including a chord or a bounce, restarts the run.
          if (keys_s != 10'd0) begin
            cnt <= 8'd0;
          end else if (cnt == CNT_LAST) begin
            cnt   <= 8'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
`timescale 1ns/1ps
module tb_keypad_encoder;
  localparam int D    = 4;
  localparam int MAXN = 4096;

  logic clock  = 1'b0;
  logic clearn = 1'b0;
  keypad_encoder_if kp_if ();

  always #5 clock = ~clock;

  keypad_encoder dut (
    .clock  (clock),
    .clearn (clearn),
    .kp     (kp_if)
  );

  int errs   = 0;
  int checks = 0;

  // Per-edge trace: the inputs present at edge e and the outputs sampled just after it.
  logic [9:0] kp_h [MAXN];
  bit         inh_h[MAXN];
  logic       lo_h [MAXN];
  logic [3:0] da_h [MAXN];
  logic       bz_h [MAXN];
  int         n;

  // Reference expectations derived from the trace.
  logic       exp_lo[MAXN];
  logic [3:0] exp_da[MAXN];
  logic       exp_bz[MAXN];
  logic [3:0] sd    [MAXN];

  typedef struct {
    logic [9:0] keys;
    int         hold;
    bit         inh;
    int         exp_cnt;
    logic [3:0] exp_data;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input logic [9:0] k, input bit inh);
    kp_if.keypad  = k;
    kp_if.inhibit = inh;
    @(posedge clock);
    #1;
    if (n < MAXN) begin
      kp_h[n]  = k;
      inh_h[n] = inh;
      lo_h[n]  = kp_if.loadn;
      da_h[n]  = kp_if.data;
      bz_h[n]  = kp_if.busy;
      n++;
    end
  endtask

  task automatic do_reset(input logic [9:0] k);
    clearn        = 1'b0;
    kp_if.keypad  = k;
    kp_if.inhibit = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      chk("rst_loadn", kp_if.loadn, 1);
      chk("rst_data",  kp_if.data,  0);
      chk("rst_busy",  kp_if.busy,  0);
    end
    clearn = 1'b1;
    n      = 0;
  endtask

  // What the FSM samples at edge e: the keypad driven two edges earlier.
  function automatic logic [9:0] samp(input int e);
    return (e >= 2) ? kp_h[e-2] : 10'd0;
  endfunction

  function automatic logic [3:0] digit_of(input logic [9:0] v);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 10; i++) if (v[i]) d = 4'(i);
    return d;
  endfunction

  function automatic int first_low(input int from);
    for (int e = from; e < n; e++) if (lo_h[e] === 1'b0) return e;
    return -1;
  endfunction

  function automatic int strobes(input int a, input int b);
    int s;
    s = 0;
    for (int e = a; e < b; e++)
      if (lo_h[e] === 1'b0 && (e == 0 || lo_h[e-1] === 1'b1)) s++;
    return s;
  endfunction

  function automatic int low_cycles(input int a, input int b);
    int s;
    s = 0;
    for (int e = a; e < b; e++) if (lo_h[e] === 1'b0) s++;
    return s;
  endfunction

  // Search-based model over the whole recorded sample sequence:
  //  armed: the first clean one-hot sample opens a window of D samples that must all
  //         match it with inhibit low. A break re-arms one sample after the break.
  //  accept: the strobe lands on the window's last sample. The next sample is ignored.
  //         Re-arming then waits for D consecutive all-zero samples.
  task automatic check_trace(input string nm);
    int   p, i, j, t, r, z, last_bz;
    bit   fail;
    logic [3:0] d;
    for (int e = 0; e < n; e++) begin
      exp_lo[e] = 1'b1;
      exp_bz[e] = 1'b0;
    end
    p = 0;
    while (p < n) begin
      i = p;
      while (i < n && !($countones(samp(i)) == 1 && !inh_h[i])) i++;
      if (i >= n) break;
      fail = 1'b0;
      j    = i + 1;
      while (j < i + D && j < n && !fail) begin
        if (inh_h[j] || samp(j) != samp(i)) fail = 1'b1;
        else j++;
      end
      if (fail) begin
        for (int e = i; e < j; e++) exp_bz[e] = 1'b1;
        p = j + 1;
        continue;
      end
      if (j < i + D) begin
        for (int e = i; e < n; e++) exp_bz[e] = 1'b1;
        break;
      end
      t         = i + D - 1;
      exp_lo[t] = 1'b0;
      sd[t]     = digit_of(samp(i));
      r = t + 2;
      z = 0;
      while (r < n && z < D) begin
        if (samp(r) == 10'd0) z++;
        else z = 0;
        r++;
      end
      last_bz = (z == D) ? r - 2 : n - 1;
      for (int e = i; e <= last_bz; e++) exp_bz[e] = 1'b1;
      p = r;
    end
    d = 4'd0;
    for (int e = 0; e < n; e++) begin
      if (!exp_lo[e]) d = sd[e];
      exp_da[e] = d;
      chk($sformatf("%s e%0d loadn", nm, e), lo_h[e], exp_lo[e]);
      chk($sformatf("%s e%0d data",  nm, e), da_h[e], exp_da[e]);
      chk($sformatf("%s e%0d busy",  nm, e), bz_h[e], exp_bz[e]);
    end
  endtask

  initial begin
    int s, fl, seen;
    logic [9:0] k;
    bit inh_ep;

    vecs[0] = '{10'b0100000000, 10, 1'b0, 1, 4'd8};
    vecs[1] = '{10'b0000100000, 10, 1'b0, 1, 4'd5};
    vecs[2] = '{10'b0010000000, 10, 1'b0, 1, 4'd7};
    vecs[3] = '{10'b1000000000, 10, 1'b1, 0, 4'd7};
    vecs[4] = '{10'b0000000110, 20, 1'b0, 0, 4'd7};
    vecs[5] = '{10'b0000000001, 10, 1'b0, 1, 4'd0};
    vecs[6] = '{10'b1000000000, 10, 1'b0, 1, 4'd9};
    vecs[7] = '{10'b0001000000,  4, 1'b0, 1, 4'd6};
    vecs[8] = '{10'b0000001000,  3, 1'b0, 0, 4'd6};

    kp_if.keypad  = '0;
    kp_if.inhibit = 1'b0;
    n             = 0;

    // Reset with key 5 held: strobe on the sixth edge after release.
    do_reset(10'b0000100000);
    for (int c = 0; c < 12; c++) tick(10'b0000100000, 1'b0);
    for (int c = 0; c < 10; c++) tick(10'd0, 1'b0);
    chk("reset_strobe_edge", first_low(0), 5);
    chk("reset_strobe_count", strobes(0, n), 1);
    check_trace("reset");

    // Table: entry sequence 8,5,7, then inhibit, chord, digit bounds and debounce length.
    do_reset(10'd0);
    for (int v = 0; v < 9; v++) begin
      s = n;
      for (int c = 0; c < vecs[v].hold + 10; c++)
        tick((c < vecs[v].hold) ? vecs[v].keys : 10'd0,
             (c < vecs[v].hold) ? vecs[v].inh : 1'b0);
      chk($sformatf("vec%0d strobes", v), strobes(s, n), vecs[v].exp_cnt);
      chk($sformatf("vec%0d low_cycles", v), low_cycles(s, n), vecs[v].exp_cnt);
      chk($sformatf("vec%0d data", v), kp_if.data, vecs[v].exp_data);
    end
    check_trace("table");

    // Bounce: key 3 toggles every 2 clocks, then holds steady.
    do_reset(10'd0);
    for (int c = 0; c < 10; c++) tick(10'b0000000010, 1'b0);
    for (int c = 0; c < 10; c++) tick(10'd0, 1'b0);
    s = n;
    for (int c = 0; c < 12; c++) begin
      tick(((c / 2) % 2 == 0) ? 10'b0000001000 : 10'd0, 1'b0);
      chk("bounce_data_held", kp_if.data, 1);
    end
    chk("bounce_no_strobe", strobes(s, n), 0);
    s = n;
    for (int c = 0; c < 10; c++) tick(10'b0000001000, 1'b0);
    fl = first_low(s);
    chk("bounce_strobe_offset", fl - s, 5);
    chk("bounce_strobe_count", strobes(s, n), 1);
    chk("bounce_data", kp_if.data, 3);
    for (int c = 0; c < 10; c++) tick(10'd0, 1'b0);
    check_trace("bounce");

    // Chord of 1+2, then key 2 alone held long.
    do_reset(10'd0);
    for (int c = 0; c < 20; c++) tick(10'b0000000110, 1'b0);
    chk("chord_no_strobe", strobes(0, n), 0);
    s = n;
    for (int c = 0; c < 40; c++) tick(10'b0000000100, 1'b0);
    chk("hold_strobe_count", strobes(s, n), 1);
    chk("hold_data", kp_if.data, 2);
    for (int c = 0; c < 10; c++) tick(10'd0, 1'b0);
    check_trace("chord_hold");

    // Inhibit dropped during the debounce of key 4. With raise=1 it returns on the
    // edge that would load and must suppress the strobe. Without it the strobe lands there.
    for (int raise = 1; raise >= 0; raise--) begin
      do_reset(10'd0);
      for (int c = 0; c < 12; c++)
        tick(10'b0000010000, (c < 3) || (raise == 1 && c >= 6));
      for (int c = 0; c < 10; c++) tick(10'd0, 1'b0);
      chk($sformatf("inh_raise%0d strobes", raise), strobes(0, n), (raise == 1) ? 0 : 1);
      chk($sformatf("inh_raise%0d data", raise), kp_if.data, (raise == 1) ? 0 : 4);
      check_trace($sformatf("inh_raise%0d", raise));
    end

    // Async reset in the middle of the low loadn cycle.
    do_reset(10'd0);
    seen = -1;
    for (int c = 0; c < 20; c++) begin
      tick(10'b0001000000, 1'b0);
      if (kp_if.loadn === 1'b0) begin
        seen = c;
        break;
      end
    end
    chk("arst_strobe_seen", seen, 5);
    #3;
    clearn = 1'b0;
    #1;
    chk("arst_loadn", kp_if.loadn, 1);
    chk("arst_data",  kp_if.data,  0);
    chk("arst_busy",  kp_if.busy,  0);
    kp_if.keypad = 10'd0;
    @(posedge clock);
    #1;
    chk("arst_hold_loadn", kp_if.loadn, 1);
    clearn = 1'b1;
    n      = 0;
    for (int c = 0; c < 8; c++) tick(10'd0, 1'b0);
    check_trace("arst_recover");

    // Random traffic: presses, bounces, chords, inhibit bursts, short gaps.
    do_reset(10'd0);
    for (int ep = 0; ep < 150; ep++) begin
      case ($urandom_range(0, 9))
        0:       k = 10'(1 << $urandom_range(0, 9)) | 10'(1 << $urandom_range(0, 9));
        1:       k = 10'd0;
        default: k = 10'(1 << $urandom_range(0, 9));
      endcase
      inh_ep = ($urandom_range(0, 4) == 0);
      for (int c = 0, h = $urandom_range(1, 12); c < h; c++)
        tick(($urandom_range(0, 9) == 0) ? 10'd0 : k, inh_ep && ($urandom_range(0, 1) == 1));
      for (int c = 0, g = $urandom_range(0, 8); c < g; c++)
        tick(10'd0, ($urandom_range(0, 7) == 0));
    end
    check_trace("random");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
